cop_muldiv: RTL and testbench

Multi-cycle multiply/divide coprocessor that executes the 3-bit operation code produced by the coprocessor op decoder and holds the architectural HI/LO registers. It sits directly downstream of that decoder, takes rs/rt operands from the register-file read stage, and feeds HI/LO back to the writeback muxes for MUL, MFHI and MFLO. The pipeline stalls while `busy` is high.

---
 rtl/cop_pkg.sv | 24 ++
 rtl/cop_div_iter.sv | 51 +++++
 rtl/cop_muldiv.sv | 168 ++++++++++++++++
 tb/tb_cop_muldiv.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cop_pkg.sv
// Shared definitions for the multiply/divide coprocessor: op codes, FSM state
// encoding and the iteration count of the shift-add / restoring datapaths.
package cop_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MADD  = 3'b001;
  localparam logic [2:0] OP_MSUBU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_NONE  = 3'b111;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // MSUBU is the only unsigned operation; everything else works on magnitudes
  function automatic logic is_signed_op(input logic [2:0] opc);
    return opc != OP_MSUBU;
  endfunction

endpackage

// File: rtl/cop_div_iter.sv
// Restoring unsigned divider, one quotient bit per step. `start` loads the
// dividend/divisor, each `step` retires one bit; after W steps quotient and
// remainder are final.
module cop_div_iter
  import cop_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_reg;
  logic [W-1:0] quo_reg;
  logic [W-1:0] dvs_reg;
  logic [W+1:0] trial;

  // Partial remainder shifted left by one with the next dividend bit, minus divisor
  assign trial = {1'b0, rem_reg, quo_reg[W-1]} - {2'b00, dvs_reg};

  // Load on start, otherwise subtract-and-restore one bit per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
    end else if (start) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
    end else if (step) begin
      if (!trial[W+1]) begin
        rem_reg <= trial[W-1:0];
        quo_reg <= {quo_reg[W-2:0], 1'b1};
      end else begin
        rem_reg <= {rem_reg[W-2:0], quo_reg[W-1]};
        quo_reg <= {quo_reg[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/cop_muldiv.sv
// Multi-cycle multiply/divide coprocessor holding the HI/LO registers.
// Optional macro COP_FAST_MUL_EN: multiplies use a single-cycle combinational
// multiplier (IDLE -> FINISH directly); DIV stays iterative.
// Results are written to HI/LO one edge after FINISH, together with `done`.
module cop_muldiv
  import cop_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int W2 = 2 * W;
  localparam int CW = $clog2(ITER);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    op_reg;
  logic [W-1:0]  a_reg;
  logic          b_zero_reg;
  logic          a_neg_reg;
  logic          b_neg_reg;
  logic [W-1:0]  mcand_reg;
  logic [W2-1:0] prod_reg;
  logic [W2-1:0] res_reg;
  logic          wb_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [W-1:0]  hi_reg;
  logic [W-1:0]  lo_reg;

  logic          accept;
  logic          sgn_op;
  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W:0]    mul_sum;
  logic [W2-1:0] prod_fix;
  logic [W2-1:0] acc;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo_fix;
  logic [W-1:0]  rem_fix;
  logic [W2-1:0] res_next;

  // Only the four defined codes start an operation, and only from IDLE
  assign accept = start && (state_reg == IDLE) && !op[2];
  assign sgn_op = is_signed_op(op);
  assign a_neg  = sgn_op && a[W-1];
  assign b_neg  = sgn_op && b[W-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;

  // Shift-add step: add multiplicand to upper half when the current LSB is set
  assign mul_sum = {1'b0, prod_reg[W2-1:W]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);

  assign acc      = {hi_reg, lo_reg};
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -prod_reg : prod_reg;
  assign quo_fix  = (a_neg_reg ^ b_neg_reg) ? -quo : quo;
  assign rem_fix  = a_neg_reg ? -rem : rem;

  cop_div_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .step      (state_reg == CALC),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sign fix-up and accumulate applied to the finished magnitude results
  always_comb begin
    res_next = prod_fix;
    case (op_reg)
      OP_MADD:  res_next = acc + prod_fix;
      OP_MSUBU: res_next = acc - prod_fix;
      OP_DIV: begin
        if (b_zero_reg) res_next = {a_reg, {W{1'b1}}};
        else            res_next = {rem_fix, quo_fix};
      end
      default: res_next = prod_fix;
    endcase
  end

  // Control FSM, iterative multiplier and HI/LO writeback with registered flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_NONE;
      a_reg      <= '0;
      b_zero_reg <= 1'b0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      res_reg    <= '0;
      wb_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      busy_reg <= (state_reg != IDLE);
      done_reg <= wb_reg;
      wb_reg   <= 1'b0;
      if (wb_reg) begin
        {hi_reg, lo_reg} <= res_reg;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op;
            a_reg      <= a;
            b_zero_reg <= (b == '0);
            a_neg_reg  <= a_neg;
            b_neg_reg  <= b_neg;
            mcand_reg  <= mag_a;
            cnt_reg    <= '0;
`ifdef COP_FAST_MUL_EN
            if (op != OP_DIV) begin
              prod_reg  <= W2'(mag_a) * W2'(mag_b);
              state_reg <= FINISH;
            end else begin
              prod_reg  <= {{W{1'b0}}, mag_b};
              state_reg <= CALC;
            end
`else
            prod_reg  <= {{W{1'b0}}, mag_b};
            state_reg <= CALC;
`endif
          end
        end
        CALC: begin
          prod_reg <= {mul_sum, prod_reg[W-1:1]};
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(ITER - 1)) begin
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          res_reg   <= res_next;
          wb_reg    <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_cop_muldiv.sv
// Directed self-checking bench for cop_muldiv. Honors COP_FAST_MUL_EN for
// the expected multiply latency.
module tb_cop_muldiv;
  import cop_pkg::*;

`ifdef COP_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = ITER + 2;
`endif
  localparam int DIV_LAT = ITER + 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic [2:0]  chain_op = OP_NONE;
  logic [31:0] chain_a = '0;
  logic [31:0] chain_b = '0;

  cop_muldiv #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] opc);
    return (opc == OP_DIV) ? DIV_LAT : MUL_LAT;
  endfunction

  // Present a command for one edge, then scramble the inputs
  task automatic launch(input logic [2:0] opc, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = opc;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    op    = OP_NONE;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
  endtask

  // Follow one operation from cycle k+n0 to k+lat+1; optionally issue the
  // chained command so it is accepted at edge k+lat
  task automatic await_op(input string name, input logic [2:0] opc, input int n0,
                          input bit chain, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int early;
    lat = lat_of(opc);
    early = 0;
    for (int n = n0; n <= lat + 1; n++) begin
      tick();
      if (n == 1) chk({name, "_busy_k1"}, busy, 1);
      if (n < lat && done) early++;
      if (n == lat - 1) begin
        chk({name, "_busy_last"}, busy, 1);
        chk({name, "_hi_hold"}, hi, prev_hi);
        chk({name, "_lo_hold"}, lo, prev_lo);
        if (chain) begin
          start = 1'b1;
          op    = chain_op;
          a     = chain_a;
          b     = chain_b;
        end
      end
      if (n == lat) begin
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        if (chain) begin
          start = 1'b0;
          op    = OP_NONE;
        end
      end
      if (n == lat + 1) chk({name, "_done_pulse"}, done, 0);
    end
    chk({name, "_early_done"}, early, 0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int dn;
    int dn_at;
    logic [31:0] got_hi;
    logic [31:0] got_lo;

    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_NONE;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst_n = 1'b1;

    // op=111 from IDLE is ignored
    launch(OP_NONE, 32'd1, 32'd2);
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("none_busy", busy, 0);
      chk("none_done", done, 0);
    end

    // MULT -3*7, back-to-back MULT 4*4 to set HI:LO = 0:0x10
    chain_op = OP_MULT; chain_a = 32'd4; chain_b = 32'd4;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    await_op("mult_neg", OP_MULT, 1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    await_op("mult_4x4", OP_MULT, 2, 1'b0, 32'h0, 32'h10);

    launch(OP_MADD, 32'd2, 32'd3);
    await_op("madd", OP_MADD, 1, 1'b0, 32'h0, 32'h16);

    launch(OP_MULT, 32'd1, 32'd5);
    await_op("mult_1x5", OP_MULT, 1, 1'b0, 32'h0, 32'h5);

    launch(OP_MSUBU, 32'd1, 32'd6);
    await_op("msubu", OP_MSUBU, 1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    await_op("div_neg", OP_DIV, 1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(OP_DIV, 32'd9, 32'd0);
    await_op("div_zero", OP_DIV, 1, 1'b0, 32'd9, 32'hFFFF_FFFF);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    await_op("div_ovf", OP_DIV, 1, 1'b0, 32'h0, 32'h8000_0000);

    // DIV 100/7 with op=111 and op=000 strobes while busy; both ignored
    launch(OP_DIV, 32'd100, 32'd7);
    dn = 0; dn_at = 0; got_hi = '0; got_lo = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        dn++;
        dn_at = n;
        got_hi = hi;
        got_lo = lo;
      end
      if (n == 1) begin start = 1'b1; op = OP_NONE; a = 32'd3; b = 32'd3; end
      if (n == 2) start = 1'b0;
      if (n == 4) begin start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3; end
      if (n == 5) begin start = 1'b0; op = OP_NONE; end
    end
    chk("ignore_done_count", dn, 1);
    chk("ignore_done_cycle", dn_at, DIV_LAT);
    chk("ignore_hi", got_hi, 32'd2);
    chk("ignore_lo", got_lo, 32'd14);
    chk("ignore_busy_after", busy, 0);
    prev_hi = 32'd2;
    prev_lo = 32'd14;

    // MULT 0x10000^2, back-to-back MADD 2*3
    chain_op = OP_MADD; chain_a = 32'd2; chain_b = 32'd3;
    launch(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    await_op("mult_big", OP_MULT, 1, 1'b1, 32'h1, 32'h0);
    await_op("madd_b2b", OP_MADD, 2, 1'b0, 32'h1, 32'h6);

    // Reset sampled at edge k+10 of a MULT
    launch(OP_MULT, 32'd5, 32'd5);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_hi_after", hi, 0);
    chk("midrst_lo_after", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
